// File: rtl/muldiv_pkg.sv
// Shared constants and helpers for the multi-cycle multiply/divide sequencer.
// Optional divide support is compiled in with the MULDIV_DIV_EN macro.
package muldiv_pkg;

  // ALU control codes handled by the sequencer
  localparam logic [3:0] OP_MULT  = 4'b1000;
  localparam logic [3:0] OP_MULTU = 4'b1001;
  localparam logic [3:0] OP_DIV   = 4'b1011;
  localparam logic [3:0] OP_DIVU  = 4'b1100;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_CNT_W = $clog2(DEF_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_SIGN = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Codes that start an operation in this build
  function automatic logic op_legal(input logic [3:0] op);
`ifdef MULDIV_DIV_EN
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
`else
    return (op == OP_MULT) || (op == OP_MULTU);
`endif
  endfunction

  // Operands are treated as two's complement
  function automatic logic op_signed(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_div(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration of the multiply/divide datapath (purely combinational).
// Optional macro: MULDIV_DIV_EN adds the restoring-division step.
// Ports:
//   is_div   in   1      select divide step (only with MULDIV_DIV_EN)
//   acc      in   WIDTH  partial product upper half / partial remainder
//   mq       in   WIDTH  multiplier (shifting out) / dividend->quotient
//   opnd     in   WIDTH  multiplicand / divisor magnitude
//   acc_nxt  out  WIDTH  acc after this step
//   mq_nxt   out  WIDTH  mq after this step
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
`ifdef MULDIV_DIV_EN
  input  logic             is_div,
`endif
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] mq,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] acc_nxt,
  output logic [WIDTH-1:0] mq_nxt
);

  // Shift-add: add multiplicand when the multiplier LSB is set, then shift
  // {carry, acc, mq} right; the carry lands in acc's MSB.
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] mul_acc;
  logic [WIDTH-1:0] mul_mq;

  assign addend  = mq[0] ? opnd : '0;
  assign sum     = {1'b0, acc} + {1'b0, addend};
  assign mul_acc = sum[WIDTH:1];
  assign mul_mq  = {sum[0], mq[WIDTH-1:1]};

`ifdef MULDIV_DIV_EN
  // Restoring divide: shift the next dividend bit into the remainder and
  // subtract the divisor when it fits. The true difference is below the
  // divisor, so the low WIDTH bits of the subtraction are exact.
  logic [WIDTH:0]   shifted;
  logic             fits;
  logic [WIDTH-1:0] sub;
  logic [WIDTH-1:0] div_acc;
  logic [WIDTH-1:0] div_mq;

  assign shifted = {acc, mq[WIDTH-1]};
  assign fits    = shifted >= {1'b0, opnd};
  assign sub     = shifted[WIDTH-1:0] - opnd;
  assign div_acc = fits ? sub : shifted[WIDTH-1:0];
  assign div_mq  = {mq[WIDTH-2:0], fits};

  assign acc_nxt = is_div ? div_acc : mul_acc;
  assign mq_nxt  = is_div ? div_mq  : mul_mq;
`else
  assign acc_nxt = mul_acc;
  assign mq_nxt  = mul_mq;
`endif

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU (and optional DIV/DIVU) sequencer owning HI/LO.
// Optional macro: MULDIV_DIV_EN enables the divide codes and hardware.
// Ports:
//   clk    in   1      rising-edge clock
//   rst_n  in   1      synchronous active-low reset
//   start  in   1      request, sampled only while idle
//   op     in   4      ALU control code
//   a      in   WIDTH  rs operand (multiplicand / dividend)
//   b      in   WIDTH  rt operand (multiplier / divisor)
//   busy   out  1      operation in flight, stalls the pipeline
//   done   out  1      one-cycle pulse, HI/LO valid
//   hi     out  WIDTH  product upper half / remainder
//   lo     out  WIDTH  product lower half / quotient
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  state_t             state;
  state_t             state_n;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   mq;
  logic [WIDTH-1:0]   opnd;
  logic               neg_lo;
`ifdef MULDIV_DIV_EN
  logic               is_div;
  logic               neg_hi;
  logic               dbz;
`endif

  logic               load;
  logic               step_en;
  logic               commit;
  logic               busy_nxt;
  logic               done_nxt;
  logic [WIDTH-1:0]   acc_nxt;
  logic [WIDTH-1:0]   mq_nxt;
  logic               sgn;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   hi_fix;
  logic [WIDTH-1:0]   lo_fix;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (start && op_legal(op)) state_n = ST_CALC;
      ST_CALC: if (cnt == CNT_W'(WIDTH - 1)) state_n = ST_SIGN;
      ST_SIGN: state_n = ST_DONE;
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Output / control decode; busy and done are registered from the next state
  always_comb begin
    load     = 1'b0;
    step_en  = 1'b0;
    commit   = 1'b0;
    busy_nxt = (state_n != ST_IDLE);
    done_nxt = (state_n == ST_DONE);
    case (state)
      ST_IDLE: load    = start && op_legal(op);
      ST_CALC: step_en = 1'b1;
      ST_SIGN: commit  = 1'b1;
      default: ;
    endcase
  end

  // Operand magnitudes for the signed codes
  assign sgn   = op_signed(op);
  assign mag_a = (sgn && a[WIDTH-1]) ? -a : a;
  assign mag_b = (sgn && b[WIDTH-1]) ? -b : b;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
`ifdef MULDIV_DIV_EN
    .is_div  (is_div),
`endif
    .acc     (acc),
    .mq      (mq),
    .opnd    (opnd),
    .acc_nxt (acc_nxt),
    .mq_nxt  (mq_nxt)
  );

  // Sign fix-up of the unsigned result; divide by zero bypasses the quotient
  // negation so LO is all ones, while HI = +/-|a| reconstructs a.
  always_comb begin
    prod   = {acc, mq};
    if (neg_lo) prod = -prod;
    hi_fix = prod[2*WIDTH-1:WIDTH];
    lo_fix = prod[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
    if (is_div) begin
      lo_fix = dbz ? '1 : (neg_lo ? -mq : mq);
      hi_fix = neg_hi ? -acc : acc;
    end
`endif
  end

  // Iteration datapath and counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      acc    <= '0;
      mq     <= '0;
      opnd   <= '0;
      neg_lo <= 1'b0;
`ifdef MULDIV_DIV_EN
      is_div <= 1'b0;
      neg_hi <= 1'b0;
      dbz    <= 1'b0;
`endif
    end else if (load) begin
      cnt    <= '0;
      acc    <= '0;
      neg_lo <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef MULDIV_DIV_EN
      is_div <= op_is_div(op);
      neg_hi <= sgn && a[WIDTH-1];
      dbz    <= (b == '0);
      if (op_is_div(op)) begin
        mq   <= mag_a;
        opnd <= mag_b;
      end else begin
        mq   <= mag_b;
        opnd <= mag_a;
      end
`else
      mq     <= mag_b;
      opnd   <= mag_a;
`endif
    end else if (step_en) begin
      acc <= acc_nxt;
      mq  <= mq_nxt;
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Architectural HI/LO and handshake outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi   <= '0;
      lo   <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_nxt;
      done <= done_nxt;
      if (commit) begin
        hi <= hi_fix;
        lo <= lo_fix;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed vector table, hand-written
// corner sequences, and randomized operations against an arithmetic model.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  localparam int unsigned W = 32;
  localparam int LAT = W + 2;  // cycle index (after the start edge) of the done pulse

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [3:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks = 0;
  int errors = 0;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    string        name;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] ehi;
    logic [W-1:0] elo;
    bit           repulse;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input string n, input logic [3:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [W-1:0] eh,
                         input logic [W-1:0] el, input bit rp);
    vec_t v;
    v.name = n; v.op = o; v.a = x; v.b = y; v.ehi = eh; v.elo = el; v.repulse = rp;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference result {hi, lo} from plain integer arithmetic
  function automatic logic [63:0] model(input logic [3:0] o, input logic [W-1:0] x,
                                        input logic [W-1:0] y);
    longint          sx, sy, q, r;
    longint unsigned ux, uy;
    logic [63:0]     res;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    res = '0;
    case (o)
      OP_MULT:  res = 64'(sx * sy);
      OP_MULTU: res = 64'(ux * uy);
      OP_DIV: begin
        if (y == '0) res = {x, 32'hFFFF_FFFF};
        else begin
          q = sx / sy;
          r = sx % sy;
          res = {r[31:0], q[31:0]};
        end
      end
      OP_DIVU: begin
        if (y == '0) res = {x, 32'hFFFF_FFFF};
        else res = {32'(ux % uy), 32'(ux / uy)};
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  // Launch one operation and observe it for a bounded window
  task automatic run_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input bit repulse, output logic [W-1:0] rh, output logic [W-1:0] rl,
                        output int lat, output int ndone, output bit busy_ok,
                        output bit hold_ok);
    logic [W-1:0] h0;
    logic [W-1:0] l0;
    @(negedge clk);
    h0 = hi; l0 = lo;
    op = o; a = x; b = y; start = 1'b1;
    lat = 0; ndone = 0; busy_ok = 1'b1; hold_ok = 1'b1; rh = '0; rl = '0;
    for (int k = 1; k <= LAT + 3; k++) begin
      @(negedge clk);
      if (k == 1) begin
        op = 4'($urandom); a = $urandom; b = $urandom;
      end
      start = repulse && (k == 10);
      if (busy !== (k <= LAT)) busy_ok = 1'b0;
      if (done === 1'b1) begin
        ndone++;
        if (lat == 0) begin
          lat = k; rh = hi; rl = lo;
        end
      end
      if (lat == 0 && (hi !== h0 || lo !== l0)) hold_ok = 1'b0;
    end
    start = 1'b0;
  endtask

  logic [W-1:0] rh, rl, h0, l0;
  int           lat, nd;
  bit           bok, hok;

  initial begin
    logic [3:0] ill[$];
    logic [3:0] legal[$];
    logic [W-1:0] specials[5];
    int first_done, second_done, k;
    bit seen_busy, seen_done;

    rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;

    // Directed table (expected values worked out by hand)
    add_vec("multu_max",  OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    add_vec("mult_m3x7",  OP_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b1);
    add_vec("multu_6x7",  OP_MULTU, 32'd6,         32'd7,         32'h0,         32'd42,        1'b0);
    add_vec("mult_minsq", OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,         1'b0);
    add_vec("mult_m1m1",  OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         32'h1,         1'b0);
    add_vec("multu_c",    OP_MULTU, 32'h8000_0000, 32'd2,         32'h1,         32'h0,         1'b0);
`ifdef MULDIV_DIV_EN
    add_vec("div_m7_2",   OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    add_vec("divu_5_0",   OP_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b0);
    add_vec("div_ovf",    OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 1'b0);
    add_vec("div_m7_0",   OP_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b0);
    add_vec("divu_100_7", OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0);
    add_vec("div_7_m2",   OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0);
`endif
    add_vec("mult_mix",   OP_MULT,  32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000, 1'b0);

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].repulse, rh, rl, lat, nd, bok, hok);
      chk({vecs[i].name, " hi"}, 64'(rh), 64'(vecs[i].ehi));
      chk({vecs[i].name, " lo"}, 64'(rl), 64'(vecs[i].elo));
      chk({vecs[i].name, " latency"}, 64'(lat), 64'(LAT));
      chk({vecs[i].name, " done count"}, 64'(nd), 64'd1);
      chk({vecs[i].name, " busy window"}, 64'(bok), 64'd1);
      chk({vecs[i].name, " hilo hold"}, 64'(hok), 64'd1);
    end

    // Illegal codes: nothing starts, HI/LO untouched
    ill.push_back(4'b0010);
    ill.push_back(4'b1111);
    ill.push_back(4'b1010);
`ifndef MULDIV_DIV_EN
    ill.push_back(OP_DIV);
    ill.push_back(OP_DIVU);
`endif
    foreach (ill[i]) begin
      @(negedge clk);
      h0 = hi; l0 = lo;
      op = ill[i]; a = $urandom; b = $urandom; start = 1'b1;
      seen_busy = 1'b0; seen_done = 1'b0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (c == 2) start = 1'b0;
        if (busy !== 1'b0) seen_busy = 1'b1;
        if (done !== 1'b0) seen_done = 1'b1;
      end
      chk($sformatf("illegal %b busy", ill[i]), 64'(seen_busy), 64'd0);
      chk($sformatf("illegal %b done", ill[i]), 64'(seen_done), 64'd0);
      chk($sformatf("illegal %b hi", ill[i]), 64'(hi), 64'(h0));
      chk($sformatf("illegal %b lo", ill[i]), 64'(lo), 64'(l0));
    end

    // Reset in the middle of a mult; HI/LO hold nonzero values beforehand
    @(negedge clk);
    op = OP_MULT; a = 32'hFFFF_FFFD; b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    chk("midop busy before reset", 64'(busy), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midop reset busy", 64'(busy), 64'd0);
    chk("midop reset hi", 64'(hi), 64'd0);
    chk("midop reset lo", 64'(lo), 64'd0);
    rst_n = 1'b1;
    run_op(OP_MULTU, 32'd6, 32'd7, 1'b0, rh, rl, lat, nd, bok, hok);
    chk("post reset hi", 64'(rh), 64'd0);
    chk("post reset lo", 64'(rl), 64'd42);
    chk("post reset latency", 64'(lat), 64'(LAT));
    chk("post reset done count", 64'(nd), 64'd1);

    // Back-to-back: start held high, dones spaced WIDTH+3 apart
    @(negedge clk);
    op = OP_MULTU; a = 32'd3; b = 32'd5; start = 1'b1;
    first_done = 0; second_done = 0;
    for (int c = 1; c <= 2 * LAT + 10; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (first_done == 0) first_done = c;
        else if (second_done == 0) second_done = c;
      end
    end
    start = 1'b0;
    chk("b2b first done", 64'(first_done), 64'(LAT));
    chk("b2b spacing", 64'(second_done - first_done), 64'(W + 3));
    chk("b2b lo", 64'(lo), 64'd15);
    k = 0;
    while (busy !== 1'b0 && k < 3 * LAT) begin
      @(negedge clk);
      k++;
    end
    chk("b2b drain idle", 64'(busy), 64'd0);

    // Randomized operations against the model
    legal.push_back(OP_MULT);
    legal.push_back(OP_MULTU);
`ifdef MULDIV_DIV_EN
    legal.push_back(OP_DIV);
    legal.push_back(OP_DIVU);
`endif
    specials[0] = 32'h0;
    specials[1] = 32'h1;
    specials[2] = 32'hFFFF_FFFF;
    specials[3] = 32'h8000_0000;
    specials[4] = 32'h7FFF_FFFF;
    for (int t = 0; t < 40; t++) begin
      logic [3:0]   ro;
      logic [W-1:0] ra, rb;
      logic [63:0]  exp;
      ro = legal[$urandom_range(legal.size() - 1)];
      ra = ($urandom_range(3) == 0) ? specials[$urandom_range(4)] : W'($urandom);
      rb = ($urandom_range(3) == 0) ? specials[$urandom_range(4)] : W'($urandom);
      if ($urandom_range(5) == 0) rb = W'($urandom_range(9));
      exp = model(ro, ra, rb);
      run_op(ro, ra, rb, 1'b0, rh, rl, lat, nd, bok, hok);
      chk($sformatf("rand%0d op%b a=%h b=%h result", t, ro, ra, rb), {rh, rl}, exp);
      chk($sformatf("rand%0d latency", t), 64'(lat), 64'(LAT));
      chk($sformatf("rand%0d done count", t), 64'(nd), 64'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
